// File: rtl/shifter_pkg.sv
// Shared FSM state encoding for the sequential left shifter.
package shifter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;
endpackage

// File: rtl/mux2to1.sv
// Generic W-bit two-input multiplexer cell.
module mux2to1 #(
  parameter int W = 16
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/shift_stage_l.sv
// One barrel stage selected at run time: shifts/rotates acc left by 2**i when en is set.
module shift_stage_l #(
  parameter int N = 4,
  parameter int W = 2**N
) (
  input  logic [W-1:0] acc,
  input  logic [N-1:0] i,
  input  logic         en,
  input  logic         rot,
  output logic [W-1:0] nxt
);
  logic [N:0][W-1:0] chain;

  assign chain[0] = acc;

  // Each constant-distance candidate is chained in; at most one k matches i, so
  // the chain passes acc through untouched everywhere else.
  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [W-1:0] shl, rol, cand;
    logic         hit;

    assign shl = acc << S;
    assign rol = (acc << S) | (acc >> (W - S));
    assign hit = en && (i == N'(k));

    mux2to1 #(.W(W)) u_mode (.d0(shl), .d1(rol), .sel(rot), .y(cand));
    mux2to1 #(.W(W)) u_pick (.d0(chain[k]), .d1(cand), .sel(hit), .y(chain[k+1]));
  end

  assign nxt = chain[N];
endmodule

// File: rtl/seq_shifter_l.sv
// Sequential left shifter: one log-stage per cycle, fixed N-cycle latency.
// Define SEQ_SHIFTER_L_ROTATE_EN to add the rotate port and rotate-left mode.
module seq_shifter_l
  import shifter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2**N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [N-1:0] shamt,
`ifdef SEQ_SHIFTER_L_ROTATE_EN
  input  logic         rotate,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y
);
  state_e       state_q, state_d;
  logic [W-1:0] acc_q, acc_d, stage_out;
  logic [N-1:0] sh_q, sh_d;
  logic [N-1:0] i_q, i_d;
  logic         rot_q, rot_d;
  logic         rot_in, stage_en;

`ifdef SEQ_SHIFTER_L_ROTATE_EN
  assign rot_in = rotate;
`else
  assign rot_in = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (i_q == N'(N-1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign stage_en = |(sh_q & (N'(1) << i_q));

  shift_stage_l #(.N(N), .W(W)) u_stage (
    .acc (acc_q),
    .i   (i_q),
    .en  (stage_en),
    .rot (rot_q),
    .nxt (stage_out)
  );

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    rot_d = rot_q;
    i_d   = i_q;
    case (state_q)
      IDLE: if (in_valid) begin
        acc_d = A;
        sh_d  = shamt;
        rot_d = rot_in;
        i_d   = '0;
      end
      SHIFT: begin
        acc_d = stage_out;
        i_d   = i_q + N'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      rot_q <= 1'b0;
      i_q   <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      rot_q <= rot_d;
      i_q   <= i_d;
    end
  end

  assign Y = acc_q;
endmodule

// File: tb/tb_seq_shifter_l.sv
// Directed self-checking bench for seq_shifter_l (N=4, W=16).
module tb_seq_shifter_l;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [3:0]  shamt;
  logic        rotate;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Y;
  int checks = 0;
  int errors = 0;

  seq_shifter_l #(.N(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .shamt(shamt),
`ifdef SEQ_SHIFTER_L_ROTATE_EN
    .rotate(rotate),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept one request, scramble the operands afterwards, and count cycles to out_valid.
  task automatic start_and_wait(input logic [15:0] a, input logic [3:0] s, input logic r,
                                output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    A = a; shamt = s; rotate = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; A = 16'h5A5A; shamt = 4'hF; rotate = ~r;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; shamt = '0; rotate = 1'b0;
    tick(); tick();
    checks++; if (Y !== 16'h0)      begin errors++; $display("FAIL reset_Y got=%h exp=0000", Y); end
    checks++; if (out_valid !== 0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1)   begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    start_and_wait(16'h0001, 4'd15, 1'b0, lat);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (Y !== 16'h8000)   begin errors++; $display("FAIL basic_Y got=%h exp=8000", Y); end
    finish_op();
  endtask

  task automatic test_zero_fill();
    int lat;
    start_and_wait(16'hF0F0, 4'd4, 1'b0, lat);
    checks++; if (Y !== 16'h0F00)   begin errors++; $display("FAIL zfill_Y got=%h exp=0f00", Y); end
    finish_op();
    start_and_wait(16'hABCD, 4'd0, 1'b0, lat);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL shamt0_latency got=%0d exp=4", lat); end
    checks++; if (Y !== 16'hABCD)   begin errors++; $display("FAIL shamt0_Y got=%h exp=abcd", Y); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    start_and_wait(16'h1234, 4'd1, 1'b0, lat);
    for (int c = 0; c < 3; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1; A = 16'hFFFF ^ 16'(c);
      tick();
      checks++; if (Y !== 16'h2468)  begin errors++; $display("FAIL bp_Y cyc=%0d got=%h exp=2468", c, Y); end
      checks++; if (in_ready !== 0)  begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, out_valid); end
    end
    in_valid = 1'b0;
    finish_op();
    checks++; if (in_ready !== 1)   begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 0)  begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    A = 16'h00FF; shamt = 4'd3; rotate = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (Y !== 16'h0)      begin errors++; $display("FAIL midrst_Y got=%h exp=0000", Y); end
    checks++; if (out_valid !== 0)  begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1)   begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 0) begin errors++; $display("FAIL midrst_no_pulse cyc=%0d got=%b exp=0", c, out_valid); end
    end
    start_and_wait(16'h0003, 4'd2, 1'b0, lat);
    checks++; if (Y !== 16'h000C)   begin errors++; $display("FAIL midrst_after_Y got=%h exp=000c", Y); end
    finish_op();
  endtask

  task automatic test_rotate();
    int lat;
    start_and_wait(16'h8001, 4'd1, 1'b1, lat);
`ifdef SEQ_SHIFTER_L_ROTATE_EN
    checks++; if (Y !== 16'h0003)   begin errors++; $display("FAIL rot_Y got=%h exp=0003", Y); end
`else
    checks++; if (Y !== 16'h0002)   begin errors++; $display("FAIL norot_Y got=%h exp=0002", Y); end
`endif
    finish_op();
    start_and_wait(16'h8001, 4'd1, 1'b0, lat);
    checks++; if (Y !== 16'h0002)   begin errors++; $display("FAIL lsl_Y got=%h exp=0002", Y); end
    finish_op();
  endtask

  task automatic test_sweep();
    int lat;
    logic [15:0] a, exp;
    for (int s = 0; s < 16; s++) begin
      a = 16'($urandom);
      exp = a << s;
      start_and_wait(a, 4'(s), 1'b0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL sweep_latency s=%0d got=%0d exp=4", s, lat); end
      checks++; if (Y !== exp) begin errors++; $display("FAIL sweep_Y s=%0d A=%h got=%h exp=%h", s, a, Y, exp); end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_fill();
    test_backpressure();
    test_reset_mid_op();
    test_rotate();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_shifter_l.md
SEQ_SHIFTER_L -- requirements
Module: seq_shifter_l

Interface
REQ-001 SHALL have parameter N, default 4, log2 of data width; data width W = 2**N.
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request carries valid operands.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have port A, input, W, operand to shift left.
REQ-007 SHALL have port shamt, input, N, shift amount, 0..W-1.
REQ-008 SHALL have port rotate, input, 1, 1 = rotate-left, 0 = logical shift-left; present only with ROTATE_EN.
REQ-009 SHALL have port out_valid, output, 1, Y holds the completed result.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts Y.
REQ-011 SHALL have port Y, output, W, result register.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE, both decoded directly from state.
REQ-014 In IDLE, in_valid=1 at an edge SHALL load acc <= A, sh <= shamt, rot <= rotate, stage counter i <= 0, and move to SHIFT.
REQ-015 In SHIFT, each edge SHALL apply stage i: if sh[i]=1, acc <= acc shifted left by 2**i; otherwise acc is unchanged. Then i <= i+1.
REQ-016 Logical mode SHALL fill the vacated LSBs with 0. Rotate mode SHALL fill them with the 2**i MSBs shifted out.
REQ-017 On the edge processing stage i=N-1, the FSM SHALL move to DONE.
REQ-018 Latency SHALL be fixed at N cycles from the acceptance edge to out_valid=1, independent of shamt (including shamt=0).
REQ-019 Y SHALL equal acc and SHALL remain stable for as long as out_valid=1.
REQ-020 In DONE, out_ready=1 at an edge SHALL return the FSM to IDLE. There is no same-edge accept of a new request.
REQ-021 in_valid SHALL be ignored outside IDLE. Changes on A, shamt or rotate after acceptance SHALL have no effect.
REQ-022 The counter i SHALL be N bits wide and SHALL NOT wrap, because SHIFT exits at i=N-1.

Reset
REQ-023 reset=0 at an edge SHALL force state IDLE, acc=0, sh=0, rot=0, i=0. Resulting outputs: Y=0, out_valid=0, in_ready=1.
REQ-024 Reset asserted during SHIFT or DONE SHALL abandon the operation. No out_valid pulse SHALL follow.
REQ-025 Reset SHALL take priority over in_valid and out_ready at the same edge.

Configuration
REQ-026 With macro SEQ_SHIFTER_L_ROTATE_EN defined, the block SHALL provide the rotate port and the rotate-left mode.
REQ-027 Without SEQ_SHIFTER_L_ROTATE_EN, the rotate port SHALL be absent, rot SHALL be tied to 0, and only logical shift-left is supported.

Structure
REQ-028 The shared package shifter_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and its encoding constants.
REQ-029 The sub-module shift_stage_l SHALL be combinational. Inputs: acc, stage index i, enable sh[i], rot. Output: next acc. It shall be built from existing mux2to1 cells.

Verification (N=4, W=16)
REQ-030 Basic: A=0x0001, shamt=15, rotate=0 -> out_valid exactly 4 cycles after accept, Y=0x8000.
REQ-031 Zero fill: A=0xF0F0, shamt=4 -> Y=0x0F00. A=0xABCD, shamt=0 -> Y=0xABCD, latency still 4.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and A -> Y stable, in_ready=0, no new accept. After out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-033 Reset mid-operation: assert reset in the 2nd SHIFT cycle -> next cycle Y=0, out_valid=0, in_ready=1. Then A=0x0003, shamt=2 -> Y=0x000C.
REQ-034 Rotate (macro defined): A=0x8001, shamt=1, rotate=1 -> Y=0x0003. Same operands with rotate=0 -> Y=0x0002. Macro undefined: logical result 0x0002.
REQ-035 Exhaustive sweep: for random A and every shamt 0..15, Y SHALL equal (A << shamt) truncated to 16 bits, with every out_valid exactly 4 cycles after accept.
